// File: rtl/sub_div_seq.sv
// rtl/sub_div_seq.sv - sequential signed divider computing (pin - cin) / bin
// Restoring division on magnitudes, one quotient bit per enabled clock.
module sub_div_seq #(
  parameter int PW = 48,
  parameter int CW = 48,
  parameter int BW = 18,
  localparam int NW = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] pin,
  input  logic signed [CW-1:0] cin,
  input  logic signed [BW-1:0] bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [NW-1:0] qout,
  output logic signed [BW-1:0] rout,
  output logic                 dz
);

  localparam int CNTW = $clog2(NW);

  typedef enum logic [2:0] {IDLE, SUB, DIV, FIX, DONE} state_t;

  state_t                state;
  logic signed [PW-1:0]  p_r;
  logic signed [PW-1:0]  c_r;
  logic signed [BW-1:0]  b_r;
  logic [NW-1:0]         dvd;
  logic [BW-1:0]         bmag;
  logic [BW:0]           prem;
  logic [CNTW-1:0]       cnt;
  logic                  sign_q;
  logic                  sign_r;

  logic signed [NW-1:0]  num;
  logic [NW-1:0]         num_mag;
  logic [BW-1:0]         b_mag;
  logic [BW+1:0]         shifted;
  logic [BW+1:0]         trial;

  // Dividend register doubles as the quotient register: bits shift out the top
  // as quotient bits shift in at the bottom.
  always_comb begin
    num     = {p_r[PW-1], p_r} - {c_r[PW-1], c_r};
    num_mag = num[NW-1] ? -num : num;
    b_mag   = b_r[BW-1] ? -b_r : b_r;
    shifted = {prem, dvd[NW-1]};
    trial   = shifted - {2'b00, bmag};
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_r       <= '0;
      c_r       <= '0;
      b_r       <= '0;
      dvd       <= '0;
      bmag      <= '0;
      prem      <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      out_valid <= 1'b0;
      qout      <= '0;
      rout      <= '0;
      dz        <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_r   <= pin;
            c_r   <= PW'(cin);
            b_r   <= bin;
            state <= SUB;
          end
        end
        SUB: begin
          sign_q <= num[NW-1] ^ b_r[BW-1];
          sign_r <= num[NW-1];
          dvd    <= num_mag;
          bmag   <= b_mag;
          prem   <= '0;
          cnt    <= CNTW'(NW - 1);
          if (b_r == '0) begin
            qout  <= '0;
            rout  <= '0;
            dz    <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          prem <= trial[BW+1] ? shifted[BW:0] : trial[BW:0];
          dvd  <= {dvd[NW-2:0], ~trial[BW+1]};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          qout      <= sign_q ? -$signed(dvd) : $signed(dvd);
          rout      <= sign_r ? -$signed(prem[BW-1:0]) : $signed(prem[BW-1:0]);
          dz        <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // A divide-by-zero enters with out_valid low and raises it one edge later.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
